divider5: RTL and testbench

Sequential 5-bit unsigned restoring divider for the adder/subtractor lab datapath. It computes quotient and remainder by repeated trial subtraction, one quotient bit per clock, and reports completion on a start/done handshake. It sits beside the 5-bit adder/subtractor and reuses the same ripple-subtract arithmetic in the divide direction.

---
 rtl/divider_pkg.sv | 15 +
 rtl/fulladder.sv | 15 +
 rtl/subtract_w.sv | 35 +++
 rtl/divider5.sv | 119 +++++++++++
 tb/tb_divider5.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// divider_pkg
//   Shared definitions for the sequential restoring divider: the FSM
//   state type, the default operand width and the iteration counter width.
package divider_pkg;

  localparam int DEFAULT_W = 5;
  localparam int CNT_W     = $clog2(DEFAULT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage : divider_pkg

// File: rtl/fulladder.sv
// fulladder
//   One-bit full adder cell used to build the ripple subtractor.
//   Ports: a, b, cin (inputs); sum, cout (outputs).
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : fulladder

// File: rtl/subtract_w.sv
// subtract_w
//   Combinational N-bit ripple subtractor: diff = a - b, built as a + ~b + 1
//   from a chain of full adders.
//   Ports: a, b (N-bit operands); diff (N-bit result);
//          borrow (1 when b > a, i.e. the inverted final carry).
module subtract_w
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_W + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] carry;

  // Carry-in of 1 completes the two's complement of b.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fulladder u_fa (
      .a   (a[i]),
      .b   (~b[i]),
      .cin (carry[i]),
      .sum (diff[i]),
      .cout(carry[i+1])
    );
  end

  // A carry out of the top bit means a >= b; its absence is a borrow.
  assign borrow = ~carry[N];

endmodule : subtract_w

// File: rtl/divider5.sv
// divider5
//   Sequential unsigned restoring divider, one quotient bit per clock.
//   Ports:
//     clk    - rising-edge clock
//     reset  - synchronous, active-high reset
//     start  - request, sampled only when busy = 0
//     A, B   - dividend and divisor, sampled with an accepted start
//     busy   - high while the division iterates
//     done   - one-cycle pulse when Q/R/Dz are valid
//     Q, R   - quotient and remainder
//     Dz     - divide-by-zero flag for the current result
module divider5
  import divider_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         Dz
);

  // Counter must hold W-1; the package value covers the default width.
  localparam int CW = (W == DEFAULT_W) ? CNT_W : $clog2(W);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  d;

  logic [W:0]    rs;
  logic [W:0]    t;
  logic          borrow;
  logic          t_msb_unused;

  // Partial remainder shifted left with the next dividend bit (held in the
  // quotient register's msb) brought in; the old R msb stays on top so the
  // trial subtraction never overflows.
  assign rs = {R, Q[W-1]};

  subtract_w #(.N(W + 1)) u_sub (
    .a     (rs),
    .b     ({1'b0, d}),
    .diff  (t),
    .borrow(borrow)
  );

  // When there is no borrow the result is below D, so its msb is always 0.
  assign t_msb_unused = t[W];

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every register sees the pre-edge value of every other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      d     <= '0;
      Q     <= '0;
      R     <= '0;
      Dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          busy <= 1'b0;
          if (start) begin
            if (B != '0) begin
              d     <= B;
              Q     <= A;
              R     <= '0;
              Dz    <= 1'b0;
              cnt   <= CW'(W - 1);
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              Q     <= '1;
              R     <= A;
              Dz    <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          if (borrow) begin
            R <= rs[W-1:0];
            Q <= {Q[W-2:0], 1'b0};
          end else begin
            R <= t[W-1:0];
            Q <= {Q[W-2:0], 1'b1};
          end
          if (cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : divider5

// File: tb/tb_divider5.sv
// tb_divider5
//   Self-checking bench for divider5: directed vector table, back-to-back
//   and mid-run reset sequences, and randomized operations compared with an
//   arithmetic reference model (integer / and %).
module tb_divider5;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] A;
  logic [4:0] B;
  logic       busy;
  logic       done;
  logic [4:0] Q;
  logic [4:0] R;
  logic       Dz;

  int checks = 0;
  int errors = 0;

  divider5 dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .Q    (Q),
    .R    (R),
    .Dz   (Dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] q;
    logic [4:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int outs_packed();
    return int'({busy, done, Q, R, Dz});
  endfunction

  // Issue one operation, wait (bounded) for done, and compare against the
  // supplied expectation. Optionally scramble A/B while the division runs.
  task automatic run_op(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] eq, input logic [4:0] er,
                        input logic edz, input int elat,
                        input bit scramble, input string tag);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else begin
        busy_cnt += int'(busy);
        if (scramble) begin
          A = 5'($urandom);
          B = 5'($urandom);
        end
      end
    end
    check({tag, " done_seen"}, int'(seen), 1);
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_cycles"}, busy_cnt, elat - 1);
    check({tag, " busy_at_done"}, int'(busy), 0);
    check({tag, " Q"}, int'(Q), int'(eq));
    check({tag, " R"}, int'(R), int'(er));
    check({tag, " Dz"}, int'(Dz), int'(edz));
    @(negedge clk);
    check({tag, " done_pulse_1cyc"}, int'(done), 0);
    check({tag, " Q_hold"}, int'(Q), int'(eq));
  endtask

  // Reference model: plain unsigned arithmetic, divide-by-zero as defined.
  task automatic model(input logic [4:0] a, input logic [4:0] b,
                       output logic [4:0] q, output logic [4:0] r,
                       output logic dz, output int lat);
    if (b == 5'd0) begin
      q = 5'h1f; r = a; dz = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = 6;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int pulses;
    int last;
    int cyc;

    vecs[0] = '{a: 5'd23, b: 5'd4,  q: 5'd5,  r: 5'd3, dz: 1'b0, lat: 6};
    vecs[1] = '{a: 5'd31, b: 5'd1,  q: 5'd31, r: 5'd0, dz: 1'b0, lat: 6};
    vecs[2] = '{a: 5'd3,  b: 5'd9,  q: 5'd0,  r: 5'd3, dz: 1'b0, lat: 6};
    vecs[3] = '{a: 5'd7,  b: 5'd0,  q: 5'd31, r: 5'd7, dz: 1'b1, lat: 1};
    vecs[4] = '{a: 5'd0,  b: 5'd5,  q: 5'd0,  r: 5'd0, dz: 1'b0, lat: 6};
    vecs[5] = '{a: 5'd31, b: 5'd31, q: 5'd1,  r: 5'd0, dz: 1'b0, lat: 6};
    vecs[6] = '{a: 5'd0,  b: 5'd0,  q: 5'd31, r: 5'd0, dz: 1'b1, lat: 1};
    vecs[7] = '{a: 5'd30, b: 5'd7,  q: 5'd4,  r: 5'd2, dz: 1'b0, lat: 6};

    reset = 1'b1; start = 1'b0; A = 5'd0; B = 5'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: all outputs low.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle[%0d]", i), outs_packed(), 0);
    end

    // Directed vectors.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
             vecs[i].lat, 1'b0, $sformatf("vec%0d", i));

    // Same vector with operands scrambled mid-run.
    run_op(5'd23, 5'd4, 5'd5, 5'd3, 1'b0, 6, 1'b1, "vec_scrambled");

    // start held high: back-to-back 30/7, A/B scrambled only while busy.
    @(negedge clk);
    A = 5'd30; B = 5'd7; start = 1'b1;
    pulses = 0; last = -1; cyc = 0;
    while (pulses < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        check($sformatf("b2b Q[%0d]", pulses), int'(Q), 4);
        check($sformatf("b2b R[%0d]", pulses), int'(R), 2);
        check($sformatf("b2b Dz[%0d]", pulses), int'(Dz), 0);
        if (last >= 0)
          check($sformatf("b2b spacing[%0d]", pulses), cyc - last, 6);
        last = cyc;
        pulses++;
      end
      if (busy) begin
        A = 5'($urandom);
        B = 5'($urandom);
      end else begin
        A = 5'd30;
        B = 5'd7;
      end
    end
    check("b2b pulses", pulses, 4);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during the third RUN cycle of 25/3.
    @(negedge clk);
    A = 5'd25; B = 5'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrun outputs_after_reset", outs_packed(), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("midrun stays_idle[%0d]", i), outs_packed(), 0);
    end
    run_op(5'd25, 5'd3, 5'd8, 5'd1, 1'b0, 6, 1'b0, "after_reset_25_3");

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      logic [4:0] a, b, eq, er;
      logic       edz;
      int         elat;
      a = 5'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      model(a, b, eq, er, edz, elat);
      run_op(a, b, eq, er, edz, elat, 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d_%0d/%0d", i, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_divider5
